vx_lsu_csr_bridge: RTL
======================

VX_LSU_CSR_BRIDGE -- requirements
Module: VX_lsu_csr_bridge

Interface
REQ-001 SHALL have parameter CSR_BASE_ADDR, default 32'hFF00_0000, byte base of the memory-mapped CSR window.
REQ-002 SHALL have parameter CSR_WINDOW_SIZE, default 32'h0000_1000, window size in bytes.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, request tag width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- req_valid, in, 1, LSU request valid.
- req_ready, out, 1, bridge accepts request.
- req_rw, in, 1, 1 = write, 0 = read.
- req_addr, in, 32, byte address.
- req_mask, in, NUM_LSU_LANES, active lanes.
- req_data, in, NUM_LSU_LANES x 32, write data per lane.
- req_tag, in, TAG_WIDTH, request tag.
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, response accepted.
- rsp_data, out, NUM_LSU_LANES x 32, read data per lane.
- rsp_tag, out, TAG_WIDTH, echoed tag.
- rsp_err, out, 1, out-of-window or misaligned access.
- csr_if, VX_lsu_to_csr_if master modport; drives write_enable, write_addr, write_data, read_enable, read_addr; samples read_data.

Function
REQ-006 FSM states SHALL be IDLE, ISSUE, CAPTURE and RSP; req_ready SHALL equal (state == IDLE).
REQ-007 Accepting a request in cycle N (req_valid && req_ready) SHALL latch rw, addr, mask, data and tag.
REQ-008 Decode: offset = req_addr - CSR_BASE_ADDR (32-bit); in_window = (req_addr >= CSR_BASE_ADDR) && (offset < CSR_WINDOW_SIZE) && (req_addr[1:0] == 0); csr address = offset[2 +: VX_CSR_ADDR_BITS].
REQ-009 If not in_window: IDLE -> RSP, with rsp_valid in N+1, rsp_err = 1, rsp_data = 0, and no CSR access.
REQ-010 If in_window and req_mask == 0: IDLE -> RSP, with rsp_valid in N+1, rsp_err = 0, rsp_data = 0, and no CSR access.
REQ-011 Write, in window, mask nonzero: IDLE -> ISSUE; write_enable SHALL be 1 for exactly cycle N+1 with the latched write_addr; write_data lanes with mask 0 SHALL be 0. Then ISSUE -> RSP, with rsp_valid in N+2, rsp_data = 0, rsp_err = 0.
REQ-012 Read, in window, mask nonzero: read_enable SHALL be 1 for exactly cycle N+1 (ISSUE). ISSUE -> CAPTURE. In N+2, read_data (CSR latency exactly 1) SHALL be registered, with masked-off lanes forced to 0. CAPTURE -> RSP, with rsp_valid in N+3.
REQ-013 All csr_if outputs and rsp_* outputs SHALL be registered; read_enable and write_enable SHALL never be 1 together.
REQ-014 In RSP, rsp_valid, rsp_data, rsp_tag and rsp_err SHALL hold stable until rsp_ready; the cycle of rsp_valid && rsp_ready SHALL transition to IDLE. A new request SHALL be accepted no earlier than the following cycle.
REQ-015 read_addr and write_addr SHALL hold their last value when the enables are 0; the enables alone qualify the access.
REQ-016 Offset arithmetic SHALL be 32-bit unsigned; req_addr below the base SHALL be treated as out of window (no wrap).

Reset
REQ-017 While reset is high: state = IDLE; req_ready = 0; rsp_valid, rsp_err, read_enable and write_enable = 0; rsp_data, rsp_tag, read_addr, write_addr and write_data = 0.
REQ-018 Reset mid-transaction SHALL drop the transaction; no enable pulse or response SHALL appear after reset deassertion. req_ready SHALL rise in the first clock edge after deassertion.

Structure
REQ-019 The state enum and the latched-request struct (rw, addr, mask, data, tag) SHALL live in VX_gpu_pkg.
REQ-020 Window decode SHALL be one combinational sub-module, VX_lsu_csr_addr_dec (inputs addr; outputs in_window, csr_addr).

Verification
Common configuration: NUM_LSU_LANES = 4, VX_CSR_ADDR_BITS = 12, default parameters.
REQ-021 Write 0xFF00_0010, mask 4'b0101, data {4,3,2,1}, tag 5 -> write_enable in N+1 only, write_addr 0x004, write_data {0,3,0,1}; rsp_valid in N+2 with tag 5, err 0.
REQ-022 Read 0xFF00_0020, mask 4'b1111; CSR returns {D,C,B,A} in N+2 -> read_addr 0x008; rsp_valid in N+3 with rsp_data {D,C,B,A}, err 0.
REQ-023 Read 0xFEFF_FFFC, then 0xFF00_1000, then 0xFF00_0002 -> each gives rsp_err 1 in N+1, data 0, no enable pulse.
REQ-024 Read response with rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready 0; IDLE the cycle after the handshake.
REQ-025 Reset asserted in ISSUE of a read -> no rsp_valid, read_enable 0 immediately; the next request completes normally.
REQ-026 In-window write with mask 0 -> no write_enable; rsp in N+1, err 0.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared types for the LSU-to-CSR bridge: lane/CSR geometry, the bridge FSM
// states, the latched-request record and a lane-masking helper.
package VX_gpu_pkg;

  localparam int NUM_LSU_LANES    = 4;
  localparam int VX_CSR_ADDR_BITS = 12;
  // Widest tag the latched-request record can carry; narrower tags are zero-extended.
  localparam int LSU_TAG_MAX_W    = 32;

  typedef logic [NUM_LSU_LANES-1:0][31:0] lane_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RSP     = 2'd3
  } lsu_csr_state_e;

  typedef struct packed {
    logic                     rw;
    logic [31:0]              addr;
    logic [NUM_LSU_LANES-1:0] mask;
    lane_data_t               data;
    logic [LSU_TAG_MAX_W-1:0] tag;
  } lsu_csr_req_t;

  // Zero every lane whose mask bit is clear.
  function automatic lane_data_t mask_lanes(lane_data_t d, logic [NUM_LSU_LANES-1:0] m);
    lane_data_t r;
    for (int i = 0; i < NUM_LSU_LANES; i++) begin
      r[i] = m[i] ? d[i] : 32'h0;
    end
    return r;
  endfunction

endpackage

// File: rtl/VX_lsu_to_csr_if.sv
// CSR-side port of the bridge. The bridge is the master: it issues single-cycle
// read/write enables; the CSR block returns read_data exactly one cycle after
// read_enable. The enables alone qualify an access; addresses may hold stale values.
interface VX_lsu_to_csr_if;

  logic                                          write_enable;
  logic [VX_gpu_pkg::VX_CSR_ADDR_BITS-1:0]       write_addr;
  VX_gpu_pkg::lane_data_t                        write_data;
  logic                                          read_enable;
  logic [VX_gpu_pkg::VX_CSR_ADDR_BITS-1:0]       read_addr;
  VX_gpu_pkg::lane_data_t                        read_data;

  modport master (
    output write_enable, write_addr, write_data, read_enable, read_addr,
    input  read_data
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_enable, read_addr,
    output read_data
  );

endinterface

// File: rtl/VX_lsu_csr_addr_dec.sv
// Combinational CSR window decode: an address hits the window when it is at or
// above the base, its 32-bit offset is below the window size, and it is word
// aligned. Addresses below the base never wrap into the window.
module VX_lsu_csr_addr_dec
  import VX_gpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFF00_0000,
  parameter logic [31:0] WINDOW_SIZE = 32'h0000_1000
) (
  input  logic [31:0]                 addr,
  output logic                        in_window,
  output logic [VX_CSR_ADDR_BITS-1:0] csr_addr
);

  logic [31:0] w_offset;

  assign w_offset  = addr - BASE_ADDR;
  assign in_window = (addr >= BASE_ADDR) && (w_offset < WINDOW_SIZE) && (addr[1:0] == 2'b00);
  assign csr_addr  = w_offset[2 +: VX_CSR_ADDR_BITS];

endmodule

// File: rtl/vx_lsu_csr_bridge.sv
// LSU-to-CSR bridge: accepts one LSU request at a time, turns in-window accesses
// into a single-cycle CSR read or write, and returns one response per request.
//
// Handshakes: a request transfers on the rising edge where req_valid && req_ready;
// a response transfers on the rising edge where rsp_valid && rsp_ready. The bridge
// holds every rsp_* output stable while rsp_valid is high and rsp_ready is low.
//
// Latency from the accept cycle N: error or empty-mask responses in N+1, writes
// in N+2, reads in N+3 (CSR read data arrives one cycle after read_enable).
module vx_lsu_csr_bridge
  import VX_gpu_pkg::*;
#(
  parameter logic [31:0] CSR_BASE_ADDR   = 32'hFF00_0000,
  parameter logic [31:0] CSR_WINDOW_SIZE = 32'h0000_1000,
  parameter int          TAG_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [31:0]              req_addr,
  input  logic [NUM_LSU_LANES-1:0] req_mask,
  input  lane_data_t               req_data,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output lane_data_t               rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic                     rsp_err,
  VX_lsu_to_csr_if.master          csr_if,
  output lsu_csr_state_e           dbg_state,
  output lsu_csr_req_t             dbg_req
);

  lsu_csr_state_e              r_state;
  logic                        r_armed;
  lsu_csr_req_t                r_req;
  logic                        r_rsp_valid;
  lane_data_t                  r_rsp_data;
  logic [TAG_WIDTH-1:0]        r_rsp_tag;
  logic                        r_rsp_err;
  logic                        r_we;
  logic [VX_CSR_ADDR_BITS-1:0] r_waddr;
  lane_data_t                  r_wdata;
  logic                        r_re;
  logic [VX_CSR_ADDR_BITS-1:0] r_raddr;

  logic                        w_in_window;
  logic [VX_CSR_ADDR_BITS-1:0] w_csr_addr;
  logic                        w_req_ready;
  logic                        w_accept;

  VX_lsu_csr_addr_dec #(
    .BASE_ADDR   (CSR_BASE_ADDR),
    .WINDOW_SIZE (CSR_WINDOW_SIZE)
  ) u_addr_dec (
    .addr      (req_addr),
    .in_window (w_in_window),
    .csr_addr  (w_csr_addr)
  );

  // r_armed keeps req_ready low until the first clock edge after reset release.
  assign w_req_ready = (r_state == IDLE) && r_armed;
  assign w_accept    = req_valid && w_req_ready;

  // Bridge FSM: latches the request, pulses the CSR enable for one cycle and
  // builds the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_re        <= 1'b0;
      r_raddr     <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.rw   <= req_rw;
            r_req.addr <= req_addr;
            r_req.mask <= req_mask;
            r_req.data <= req_data;
            r_req.tag  <= LSU_TAG_MAX_W'(req_tag);
            if (!w_in_window || (req_mask == '0)) begin
              // Nothing to touch in the CSR block: answer immediately.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= !w_in_window;
              r_rsp_data  <= '0;
              r_rsp_tag   <= req_tag;
              r_state     <= RSP;
            end else if (req_rw) begin
              r_we    <= 1'b1;
              r_waddr <= w_csr_addr;
              r_wdata <= mask_lanes(req_data, req_mask);
              r_state <= ISSUE;
            end else begin
              r_re    <= 1'b1;
              r_raddr <= w_csr_addr;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_we <= 1'b0;
          r_re <= 1'b0;
          if (r_req.rw) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= r_req.tag[TAG_WIDTH-1:0];
            r_state     <= RSP;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // CSR read data is valid exactly one cycle after read_enable.
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= mask_lanes(csr_if.read_data, r_req.mask);
          r_rsp_tag   <= r_req.tag[TAG_WIDTH-1:0];
          r_state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready           = w_req_ready;
  assign rsp_valid           = r_rsp_valid;
  assign rsp_data            = r_rsp_data;
  assign rsp_tag             = r_rsp_tag;
  assign rsp_err             = r_rsp_err;
  assign csr_if.write_enable = r_we;
  assign csr_if.write_addr   = r_waddr;
  assign csr_if.write_data   = r_wdata;
  assign csr_if.read_enable  = r_re;
  assign csr_if.read_addr    = r_raddr;
  assign dbg_state           = r_state;
  assign dbg_req             = r_req;

endmodule
